// File: rtl/conv_layer_storage_if.sv
// Address, data and enable bundle for the convolution-layer storage block.
// The master drives addresses/enables/write data; the slave returns read words.
interface conv_layer_storage_if #(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_SIZE  = 64
);
    logic                            act_we;
    logic [DATA_SIZE-1:0]            act_wdata;
    logic [15:0]                     act_wentry, act_wy, act_wx;
    logic [15:0]                     act_ry, act_rx;
    logic [NUM_INPUTS*DATA_SIZE-1:0] act_rdata;

    logic                            wt_we, bias_we;
    logic [DATA_SIZE-1:0]            wt_wdata;
    logic [15:0]                     wt_win, wt_wout, wt_wky, wt_wkx;
    logic [15:0]                     wt_rout, wt_rky, wt_rkx;
    logic [NUM_INPUTS*DATA_SIZE-1:0] wt_rdata;
    logic [15:0]                     bias_rindex;
    logic [DATA_SIZE-1:0]            bias_rdata;

    logic                            out_we;
    logic [DATA_SIZE-1:0]            out_wdata;
    logic [15:0]                     out_wentry, out_wy, out_wx;
    logic [15:0]                     out_rentry, out_ry, out_rx;
    logic [DATA_SIZE-1:0]            out_rdata;

    modport master (
        output act_we, act_wdata, act_wentry, act_wy, act_wx, act_ry, act_rx,
        output wt_we, bias_we, wt_wdata, wt_win, wt_wout, wt_wky, wt_wkx,
        output wt_rout, wt_rky, wt_rkx, bias_rindex,
        output out_we, out_wdata, out_wentry, out_wy, out_wx, out_rentry, out_ry, out_rx,
        input  act_rdata, wt_rdata, bias_rdata, out_rdata
    );

    modport slave (
        input  act_we, act_wdata, act_wentry, act_wy, act_wx, act_ry, act_rx,
        input  wt_we, bias_we, wt_wdata, wt_win, wt_wout, wt_wky, wt_wkx,
        input  wt_rout, wt_rky, wt_rkx, bias_rindex,
        input  out_we, out_wdata, out_wentry, out_wy, out_wx, out_rentry, out_ry, out_rx,
        output act_rdata, wt_rdata, bias_rdata, out_rdata
    );
endinterface

// File: rtl/conv_layer_storage.sv
// Activation, weight/bias and output memories of one convolution layer.
// Registered writes with range guards; combinational, zero-on-out-of-range reads.
module conv_layer_storage #(
    parameter int NUM_INPUTS  = 1,
    parameter int INPUT_DIM   = 5,
    parameter int NUM_OUTPUTS = 1,
    parameter int KERNEL_DIM  = 3,
    parameter int DATA_SIZE   = 64,
    parameter int OUTPUT_DIM  = INPUT_DIM - KERNEL_DIM + 1
) (
    input logic                 clk,
    input logic                 rst,
    conv_layer_storage_if.slave bus
);
    localparam int ACT_N  = NUM_INPUTS * INPUT_DIM * INPUT_DIM;
    localparam int WT_N   = NUM_INPUTS * NUM_OUTPUTS * KERNEL_DIM * KERNEL_DIM;
    localparam int OUT_N  = NUM_OUTPUTS * OUTPUT_DIM * OUTPUT_DIM;
    localparam int ACT_W  = (ACT_N > 1) ? $clog2(ACT_N) : 1;
    localparam int WT_W   = (WT_N > 1) ? $clog2(WT_N) : 1;
    localparam int OUT_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int BIAS_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    // Arrays are flattened row-major in their declared [a][b][c]... order.
    logic [DATA_SIZE-1:0] r_act  [ACT_N];
    logic [DATA_SIZE-1:0] r_wt   [WT_N];
    logic [DATA_SIZE-1:0] r_bias [NUM_OUTPUTS];
    logic [DATA_SIZE-1:0] r_out  [OUT_N];

    function automatic logic f_lt(input logic [15:0] a, input int lim);
        return int'(a) < lim;
    endfunction

    logic             w_act_wok, w_wt_wok, w_bias_wok, w_out_wok;
    logic [ACT_W-1:0] w_act_widx;
    logic [WT_W-1:0]  w_wt_widx;
    logic [BIAS_W-1:0] w_bias_widx;
    logic [OUT_W-1:0] w_out_widx;

    assign w_act_wok = bus.act_we && f_lt(bus.act_wentry, NUM_INPUTS)
                       && f_lt(bus.act_wy, INPUT_DIM) && f_lt(bus.act_wx, INPUT_DIM);
    assign w_wt_wok  = bus.wt_we && f_lt(bus.wt_win, NUM_INPUTS) && f_lt(bus.wt_wout, NUM_OUTPUTS)
                       && f_lt(bus.wt_wky, KERNEL_DIM) && f_lt(bus.wt_wkx, KERNEL_DIM);
    assign w_bias_wok = bus.bias_we && f_lt(bus.wt_wout, NUM_OUTPUTS);
    assign w_out_wok = bus.out_we && f_lt(bus.out_wentry, NUM_OUTPUTS)
                       && f_lt(bus.out_wy, OUTPUT_DIM) && f_lt(bus.out_wx, OUTPUT_DIM);

    assign w_act_widx  = ACT_W'((int'(bus.act_wentry) * INPUT_DIM + int'(bus.act_wy))
                                * INPUT_DIM + int'(bus.act_wx));
    assign w_wt_widx   = WT_W'(((int'(bus.wt_win) * NUM_OUTPUTS + int'(bus.wt_wout))
                                * KERNEL_DIM + int'(bus.wt_wky)) * KERNEL_DIM + int'(bus.wt_wkx));
    assign w_bias_widx = BIAS_W'(int'(bus.wt_wout));
    assign w_out_widx  = OUT_W'((int'(bus.out_wentry) * OUTPUT_DIM + int'(bus.out_wy))
                                * OUTPUT_DIM + int'(bus.out_wx));

    // NOTE: every memory word must clear on reset, so these are flops rather than RAM macros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ACT_N; k++)       r_act[k]  <= '0;
            for (int k = 0; k < WT_N; k++)        r_wt[k]   <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) r_bias[k] <= '0;
            for (int k = 0; k < OUT_N; k++)       r_out[k]  <= '0;
        end else begin
            // NOTE: non-blocking writes keep same-cycle reads on the pre-edge value.
            if (w_act_wok)  r_act[w_act_widx]   <= bus.act_wdata;
            if (w_wt_wok)   r_wt[w_wt_widx]     <= bus.wt_wdata;
            if (w_bias_wok) r_bias[w_bias_widx] <= bus.wt_wdata;
            if (w_out_wok)  r_out[w_out_widx]   <= bus.out_wdata;
        end
    end

    logic                            w_act_rok, w_wt_rok, w_bias_rok, w_out_rok;
    logic [NUM_INPUTS*DATA_SIZE-1:0] w_act_rd, w_wt_rd;

    assign w_act_rok  = f_lt(bus.act_ry, INPUT_DIM) && f_lt(bus.act_rx, INPUT_DIM);
    assign w_wt_rok   = f_lt(bus.wt_rout, NUM_OUTPUTS) && f_lt(bus.wt_rky, KERNEL_DIM)
                        && f_lt(bus.wt_rkx, KERNEL_DIM);
    assign w_bias_rok = f_lt(bus.bias_rindex, NUM_OUTPUTS);
    assign w_out_rok  = f_lt(bus.out_rentry, NUM_OUTPUTS) && f_lt(bus.out_ry, OUTPUT_DIM)
                        && f_lt(bus.out_rx, OUTPUT_DIM);

    always_comb begin
        w_act_rd = '0;
        w_wt_rd  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_act_rok)
                w_act_rd[i*DATA_SIZE +: DATA_SIZE] =
                    r_act[ACT_W'((i * INPUT_DIM + int'(bus.act_ry)) * INPUT_DIM + int'(bus.act_rx))];
            if (w_wt_rok)
                w_wt_rd[i*DATA_SIZE +: DATA_SIZE] =
                    r_wt[WT_W'(((i * NUM_OUTPUTS + int'(bus.wt_rout)) * KERNEL_DIM
                                + int'(bus.wt_rky)) * KERNEL_DIM + int'(bus.wt_rkx))];
        end
    end

    assign bus.act_rdata  = w_act_rd;
    assign bus.wt_rdata   = w_wt_rd;
    assign bus.bias_rdata = w_bias_rok ? r_bias[BIAS_W'(int'(bus.bias_rindex))] : '0;
    assign bus.out_rdata  = w_out_rok
                            ? r_out[OUT_W'((int'(bus.out_rentry) * OUTPUT_DIM + int'(bus.out_ry))
                                           * OUTPUT_DIM + int'(bus.out_rx))]
                            : '0;
endmodule

// File: tb/tb_conv_layer_storage.sv
// Directed bench for conv_layer_storage with 2 inputs, 2 outputs, 5x5 plane, 3x3 kernel.
// A read-vector table covers stored data, aliases of rejected writes and out-of-range reads.
module tb_conv_layer_storage;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int DS = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    conv_layer_storage_if #(.NUM_INPUTS(NI), .DATA_SIZE(DS)) bus ();

    conv_layer_storage #(
        .NUM_INPUTS(NI), .INPUT_DIM(5), .NUM_OUTPUTS(NO), .KERNEL_DIM(3), .DATA_SIZE(DS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [15:0]        ary, arx;
        logic [15:0]        wro, wrky, wrkx;
        logic [15:0]        bri;
        logic [15:0]        ore, ory, orx;
        logic [NI*DS-1:0]   e_act, e_wt;
        logic [DS-1:0]      e_bias, e_out;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.act_we = 0; bus.wt_we = 0; bus.bias_we = 0; bus.out_we = 0;
        bus.act_wdata = '0; bus.wt_wdata = '0; bus.out_wdata = '0;
        bus.act_wentry = 0; bus.act_wy = 0; bus.act_wx = 0;
        bus.wt_win = 0; bus.wt_wout = 0; bus.wt_wky = 0; bus.wt_wkx = 0;
        bus.out_wentry = 0; bus.out_wy = 0; bus.out_wx = 0;
    endtask

    task automatic set_rd(input vec_t v);
        bus.act_ry = v.ary; bus.act_rx = v.arx;
        bus.wt_rout = v.wro; bus.wt_rky = v.wrky; bus.wt_rkx = v.wrkx;
        bus.bias_rindex = v.bri;
        bus.out_rentry = v.ore; bus.out_ry = v.ory; bus.out_rx = v.orx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic act_w(input int e, input int y, input int x, input logic [DS-1:0] d);
        bus.act_we = 1; bus.act_wentry = 16'(e); bus.act_wy = 16'(y); bus.act_wx = 16'(x);
        bus.act_wdata = d;
    endtask

    task automatic wt_w(input logic we, input logic be, input int i, input int o,
                        input int ky, input int kx, input logic [DS-1:0] d);
        bus.wt_we = we; bus.bias_we = be; bus.wt_win = 16'(i); bus.wt_wout = 16'(o);
        bus.wt_wky = 16'(ky); bus.wt_wkx = 16'(kx); bus.wt_wdata = d;
    endtask

    task automatic out_w(input int e, input int y, input int x, input logic [DS-1:0] d);
        bus.out_we = 1; bus.out_wentry = 16'(e); bus.out_wy = 16'(y); bus.out_wx = 16'(x);
        bus.out_wdata = d;
    endtask

    initial begin
        vec_t z;
        z = '{ary:0, arx:0, wro:0, wrky:0, wrkx:0, bri:0, ore:0, ory:0, orx:0,
              e_act:'0, e_wt:'0, e_bias:'0, e_out:'0};

        vecs[0] = '{ary:1, arx:2, wro:1, wrky:2, wrkx:0, bri:1, ore:1, ory:2, orx:2,
                    e_act:{64'h4000000000000000, 64'h3FF0000000000000},
                    e_wt:{64'hA, 64'h0}, e_bias:64'hB, e_out:64'h55};
        vecs[1] = '{ary:1, arx:3, wro:1, wrky:2, wrkx:1, bri:0, ore:0, ory:0, orx:1,
                    e_act:'0, e_wt:'0, e_bias:64'hC, e_out:64'h77};
        vecs[2] = '{ary:0, arx:0, wro:0, wrky:0, wrkx:0, bri:2, ore:1, ory:0, orx:2,
                    e_act:'0, e_wt:{64'h0, 64'hC}, e_bias:'0, e_out:'0};
        vecs[3] = '{ary:5, arx:2, wro:1, wrky:2, wrkx:3, bri:1, ore:0, ory:3, orx:2,
                    e_act:'0, e_wt:'0, e_bias:64'hB, e_out:'0};

        idle();
        set_rd(z);
        rst = 1;
        tick();
        rst = 0;
        check("reset act",  bus.act_rdata,  '0);
        check("reset wt",   bus.wt_rdata,   '0);
        check("reset bias", bus.bias_rdata, '0);
        check("reset out",  bus.out_rdata,  '0);

        act_w(0, 1, 2, 64'h3FF0000000000000);
        wt_w(1, 0, 1, 1, 2, 0, 64'hA);
        out_w(1, 2, 2, 64'h55);
        tick();
        idle();
        act_w(1, 1, 2, 64'h4000000000000000);
        wt_w(0, 1, 0, 1, 0, 0, 64'hB);
        out_w(0, 0, 1, 64'h77);
        tick();
        idle();
        wt_w(1, 1, 0, 0, 0, 0, 64'hC);
        tick();
        idle();
        // Rejected writes whose flattened index would alias a real location.
        act_w(2, 1, 2, 64'hDEAD);
        wt_w(1, 0, 0, 1, 2, 3, 64'hEEEE);
        out_w(0, 3, 2, 64'hFFFF);
        tick();
        idle();
        act_w(0, 5, 0, 64'hBEEF);
        wt_w(0, 1, 0, 2, 0, 0, 64'h1111);
        tick();
        idle();

        for (int i = 0; i < 4; i++) begin
            set_rd(vecs[i]);
            #1;
            check($sformatf("vec%0d act", i),  bus.act_rdata,  vecs[i].e_act);
            check($sformatf("vec%0d wt", i),   bus.wt_rdata,   vecs[i].e_wt);
            check($sformatf("vec%0d bias", i), bus.bias_rdata, vecs[i].e_bias);
            check($sformatf("vec%0d out", i),  bus.out_rdata,  vecs[i].e_out);
        end

        set_rd(vecs[0]);
        out_w(1, 2, 2, 64'h66);
        #1;
        check("out old before edge", bus.out_rdata, 64'h55);
        tick();
        idle();
        check("out new after edge", bus.out_rdata, 64'h66);

        set_rd(vecs[0]);
        bus.act_ry = 0; bus.act_rx = 0;
        rst = 1;
        act_w(0, 0, 0, 64'h1234);
        tick();
        check("rst prio act",  bus.act_rdata,  '0);
        check("rst clear wt",  bus.wt_rdata,   '0);
        check("rst clear bias", bus.bias_rdata, '0);
        check("rst clear out", bus.out_rdata,  '0);
        rst = 0;
        tick();
        idle();
        check("write after rst", bus.act_rdata, {64'h0, 64'h1234});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_storage.md
# conv_layer_storage

Storage subsystem of one convolution layer. It holds three memories behind a single clock:
- a parallel activation memory that reads the same (y,x) location from every input channel at once;
- a weight/bias memory that reads one kernel tap for every input channel of a chosen output channel;
- an output memory written one word at a time and read back by the host.

Words are opaque DATA_SIZE-bit values (IEEE-754 double bit patterns in practice); the block performs no arithmetic.

## Interface
Parameters:
- NUM_INPUTS, 1: input channels (activation entries, weight input dimension).
- INPUT_DIM, 5: activation plane side length.
- NUM_OUTPUTS, 1: output channels (weight output dimension, bias count, output entries).
- KERNEL_DIM, 3: kernel side length.
- DATA_SIZE, 64: word width.
- OUTPUT_DIM, INPUT_DIM-KERNEL_DIM+1: output plane side length.

Ports:
- clk  in  1  clock; all writes on rising edge.
- rst  in  1  synchronous, active-high reset.
- act_we  in  1  activation write enable.
- act_wdata  in  DATA_SIZE  activation write word.
- act_wentry, act_wy, act_wx  in  16 each  activation write address [entry][y][x].
- act_ry, act_rx  in  16 each  activation read address.
- act_rdata  out  NUM_INPUTS*DATA_SIZE  entry i at bits [i*DATA_SIZE +: DATA_SIZE].
- wt_we  in  1  weight write enable.
- bias_we  in  1  bias write enable.
- wt_wdata  in  DATA_SIZE  weight/bias write word.
- wt_win, wt_wout, wt_wky, wt_wkx  in  16 each  weight write address [in][out][ky][kx]; the bias write address is wt_wout.
- wt_rout, wt_rky, wt_rkx  in  16 each  weight read address.
- wt_rdata  out  NUM_INPUTS*DATA_SIZE  weight[i][wt_rout][wt_rky][wt_rkx] for each input i, same packing as act_rdata.
- bias_rindex  in  16  bias read address.
- bias_rdata  out  DATA_SIZE  bias[bias_rindex].
- out_we  in  1  output-memory write enable.
- out_wdata  in  DATA_SIZE  output write word.
- out_wentry, out_wy, out_wx  in  16 each  output write address.
- out_rentry, out_ry, out_rx  in  16 each  output read address.
- out_rdata  out  DATA_SIZE  out[out_rentry][out_ry][out_rx].

## Operation
- Arrays:
  - act[NUM_INPUTS][INPUT_DIM][INPUT_DIM]
  - weight[NUM_INPUTS][NUM_OUTPUTS][KERNEL_DIM][KERNEL_DIM]
  - bias[NUM_OUTPUTS]
  - out[NUM_OUTPUTS][OUTPUT_DIM][OUTPUT_DIM]
- Reads are combinational (asynchronous) from current address inputs.
- act_rdata slice i = act[i][act_ry][act_rx] for all i in parallel.
- Writes:
  - on a rising edge with an enable high, store the write word at the write address;
  - the four write ports are independent and may all fire in the same cycle;
  - wt_we and bias_we together write both the weight and the bias from wt_wdata.
- Range checks:
  - any write with any address component out of range (entry/in ≥ count, coordinate ≥ dimension) is ignored and no location changes;
  - any read with an out-of-range component returns all-zero for that word.
- Reset:
  - rst high at a rising edge clears every location of all four arrays to 0;
  - reset has priority over writes in the same cycle;
  - outputs therefore read 0 after reset.
- Before the first reset, contents are undefined.

## Timing
- Write latency 1 cycle: data written at edge N is visible combinationally on the read outputs right after edge N.
- Simultaneous read and write of the same address in cycle N returns the old value until edge N.
- Read latency 0: outputs follow address changes within the same cycle, with no registers on the read path.
- No handshake; enables are level-sampled on each rising edge, one write per port per cycle.
- Reset mid-sequence discards all stored data; writes resume on the first edge with rst low.

## Test plan
- Reset then read: assert rst 1 cycle; read act(0,0), wt(0,0,0), bias 0, out(0,0,0) -> all 0.
- Parallel activation (NUM_INPUTS=2, INPUT_DIM=5):
  - write act[0][1][2]=0x3FF0000000000000 and act[1][1][2]=0x4000000000000000;
  - set act_ry=1, act_rx=2 -> slice0=0x3FF0…, slice1=0x4000…;
  - act_rx=3 -> both slices 0.
- Weight/bias (NUM_OUTPUTS=2, KERNEL_DIM=3):
  - write weight[1][1][2][0]=0xA and bias[1]=0xB in the same cycle;
  - wt_rout=1, wt_rky=2, wt_rkx=0 -> slice1=0xA, slice0=0;
  - bias_rindex=1 -> 0xB.
- Output memory: write out[1][2][2]=0x55, read same address -> 0x55; same cycle, write out[1][2][2]=0x66 -> read shows 0x55 until the edge, then 0x66.
- Out-of-range: write act entry=NUM_INPUTS, weight kx=KERNEL_DIM, out y=OUTPUT_DIM -> every in-range location is unchanged, and the corresponding reads return 0.
- Reset vs write: rst and act_we high together -> location stays 0; next cycle, write with rst low takes effect.
